// File: rtl/convo_core.sv
// 3x3 convolution engine: four parallel filters over a generated activation image.
// Weights come from a fixed internal table; each window yields four truncated 8-bit psums.
module convo_core #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_F  = 4,
   parameter int unsigned K      = 3,
   parameter int unsigned ACC_W  = 24
) (
   input  logic              clk_0,
   input  logic              rst_0,
   input  logic              en_0,
   input  logic              addr_rst_0,
   input  logic [11:0]       channel_0,
   input  logic [2:0]        stride_0,
   input  logic [11:0]       width_0,
   input  logic              init_signal_0,
   input  logic              load_weight_start,
   output logic [DATA_W-1:0] out_psum0_0,
   output logic [DATA_W-1:0] out_psum1_0,
   output logic [DATA_W-1:0] out_psum2_0,
   output logic [DATA_W-1:0] out_psum3_0,
   output logic              out_psum_vld_0,
   output logic              weight_done
);

   localparam int unsigned NTAP = K * K;

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StFlush} state_e;

   state_e            state_q;
   logic [DATA_W-1:0] wgt_q  [NUM_F][NTAP];
   logic [ACC_W-1:0]  acc_q  [NUM_F];
   logic [DATA_W-1:0] psum_q [NUM_F];
   logic [3:0]        ld_q;
   logic [11:0]       c_q, w_q;
   logic [2:0]        s_q;
   logic [11:0]       chan_q, row0_q, col0_q;
   logic [1:0]        kr_q, kc_q;
   logic [7:0]        plane_q;
   logic              pending_q, vld_q, done_q;

   logic [3:0]          tap;
   logic [7:0]          rowa, act, wsq;
   logic                col_last, row_last, chan_last, accept_init;
   logic [2*DATA_W-1:0] prod [NUM_F];

   // Activation address only matters mod 256, so everything is folded to 8 bits.
   always_comb begin
      tap      = {2'b00, kr_q} * 4'd3 + {2'b00, kc_q};
      rowa     = row0_q[7:0] + {6'b0, kr_q};
      act      = plane_q + rowa * w_q[7:0] + col0_q[7:0] + {6'b0, kc_q};
      wsq      = w_q[7:0] * w_q[7:0];
      col_last = ({1'b0, col0_q} + {10'b0, s_q} + 13'd3) > {1'b0, w_q};
      row_last = ({1'b0, row0_q} + {10'b0, s_q} + 13'd3) > {1'b0, w_q};
      chan_last = (chan_q == c_q - 12'd1);
      accept_init = init_signal_0 && done_q && (channel_0 != 12'd0) && (width_0 >= 12'd3);
      for (int unsigned f = 0; f < NUM_F; f++) begin
         prod[f] = (2*DATA_W)'(act) * (2*DATA_W)'(wgt_q[f][tap]);
      end
   end

   always_ff @(posedge clk_0) begin
      if (rst_0) begin
         state_q   <= StIdle;
         ld_q      <= '0;
         c_q       <= '0;
         w_q       <= '0;
         s_q       <= '0;
         chan_q    <= '0;
         row0_q    <= '0;
         col0_q    <= '0;
         kr_q      <= '0;
         kc_q      <= '0;
         plane_q   <= '0;
         pending_q <= 1'b0;
         vld_q     <= 1'b0;
         done_q    <= 1'b0;
         for (int unsigned f = 0; f < NUM_F; f++) begin
            acc_q[f]  <= '0;
            psum_q[f] <= '0;
            for (int unsigned k = 0; k < NTAP; k++) wgt_q[f][k] <= '0;
         end
      end else if (en_0) begin
         vld_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (load_weight_start) begin
                  state_q <= StLoad;
                  ld_q    <= '0;
                  done_q  <= 1'b0;
               end else if (addr_rst_0 || accept_init) begin
                  chan_q  <= '0;
                  row0_q  <= '0;
                  col0_q  <= '0;
                  kr_q    <= '0;
                  kc_q    <= '0;
                  plane_q <= '0;
                  if (!addr_rst_0) begin
                     state_q <= StRun;
                     c_q     <= channel_0;
                     w_q     <= width_0;
                     s_q     <= (stride_0 == 3'd0) ? 3'd1 : stride_0;
                  end
               end
            end
            StLoad: begin
               if (ld_q == 4'(NTAP)) begin
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  for (int unsigned f = 0; f < NUM_F; f++) begin
                     wgt_q[f][ld_q] <= DATA_W'(f * NTAP + 32'(ld_q) + 1);
                  end
                  ld_q <= ld_q + 4'd1;
               end
            end
            StRun, StFlush: begin
               if (addr_rst_0) begin
                  state_q   <= StIdle;
                  chan_q    <= '0;
                  row0_q    <= '0;
                  col0_q    <= '0;
                  kr_q      <= '0;
                  kc_q      <= '0;
                  plane_q   <= '0;
                  pending_q <= 1'b0;
                  for (int unsigned f = 0; f < NUM_F; f++) acc_q[f] <= '0;
               end else begin
                  // Emitting the finished window overlaps tap 0 of the next one.
                  if (pending_q) begin
                     for (int unsigned f = 0; f < NUM_F; f++) psum_q[f] <= acc_q[f][DATA_W-1:0];
                     vld_q     <= 1'b1;
                     pending_q <= 1'b0;
                  end
                  if (state_q == StFlush) begin
                     state_q <= StIdle;
                  end else begin
                     for (int unsigned f = 0; f < NUM_F; f++) begin
                        acc_q[f] <= (tap == 4'd0) ? ACC_W'(prod[f]) : acc_q[f] + ACC_W'(prod[f]);
                     end
                     if (kc_q == 2'd2) begin
                        kc_q <= '0;
                        if (kr_q == 2'd2) begin
                           kr_q      <= '0;
                           pending_q <= 1'b1;
                           if (col_last) begin
                              col0_q <= '0;
                              if (row_last) begin
                                 row0_q <= '0;
                                 if (chan_last) begin
                                    state_q <= StFlush;
                                 end else begin
                                    chan_q  <= chan_q + 12'd1;
                                    plane_q <= plane_q + wsq;
                                 end
                              end else begin
                                 row0_q <= row0_q + {9'b0, s_q};
                              end
                           end else begin
                              col0_q <= col0_q + {9'b0, s_q};
                           end
                        end else begin
                           kr_q <= kr_q + 2'd1;
                        end
                     end else begin
                        kc_q <= kc_q + 2'd1;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_psum0_0    = psum_q[0];
   assign out_psum1_0    = psum_q[1];
   assign out_psum2_0    = psum_q[2];
   assign out_psum3_0    = psum_q[3];
   assign out_psum_vld_0 = vld_q;
   assign weight_done    = done_q;

endmodule

// File: tb/tb_convo_core.sv
// Bench for convo_core: randomized runs checked against a direct convolution model.
module tb_convo_core;

   logic        clk_0 = 1'b0;
   logic        rst_0 = 1'b1;
   logic        en_0 = 1'b1;
   logic        addr_rst_0 = 1'b0;
   logic [11:0] channel_0 = '0;
   logic [2:0]  stride_0 = '0;
   logic [11:0] width_0 = '0;
   logic        init_signal_0 = 1'b0;
   logic        load_weight_start = 1'b0;
   logic [7:0]  out_psum0_0, out_psum1_0, out_psum2_0, out_psum3_0;
   logic        out_psum_vld_0;
   logic        weight_done;

   convo_core dut (
      .clk_0             (clk_0),
      .rst_0             (rst_0),
      .en_0              (en_0),
      .addr_rst_0        (addr_rst_0),
      .channel_0         (channel_0),
      .stride_0          (stride_0),
      .width_0           (width_0),
      .init_signal_0     (init_signal_0),
      .load_weight_start (load_weight_start),
      .out_psum0_0       (out_psum0_0),
      .out_psum1_0       (out_psum1_0),
      .out_psum2_0       (out_psum2_0),
      .out_psum3_0       (out_psum3_0),
      .out_psum_vld_0    (out_psum_vld_0),
      .weight_done       (weight_done)
   );

   always #5 clk_0 = ~clk_0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic        edge_en = 1'b0;
   logic [31:0] obs_v[$];
   int          obs_c[$];

   // Strobes count only on edges where the core was actually enabled.
   always @(posedge clk_0) begin
      cyc = cyc + 1;
      edge_en = en_0 && !rst_0;
   end

   always @(negedge clk_0) begin
      if (edge_en && out_psum_vld_0) begin
         obs_v.push_back({out_psum3_0, out_psum2_0, out_psum1_0, out_psum0_0});
         obs_c.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_0);
      #1;
   endtask

   function automatic logic [31:0] ref_psums(int c, int w, int s, int orow, int ocol);
      logic [31:0] r;
      r = '0;
      for (int f = 0; f < 4; f++) begin
         int acc;
         acc = 0;
         for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
               int a;
               a = (c * w * w + (orow * s + kr) * w + (ocol * s + kc)) % 256;
               acc += a * (f * 9 + kr * 3 + kc + 1);
            end
         end
         r[f*8 +: 8] = 8'(acc % 256);
      end
      return r;
   endfunction

   task automatic expect_none(input int c, input int w, input int s);
      obs_v.delete();
      obs_c.delete();
      channel_0 = 12'(c);
      width_0 = 12'(w);
      stride_0 = 3'(s);
      init_signal_0 = 1'b1;
      tick();
      init_signal_0 = 1'b0;
      repeat (40) tick();
      check($sformatf("no_strobe_c%0d_w%0d", c, w), obs_v.size(), 0);
   endtask

   task automatic do_run(input int c, input int w, input int s, input int gap_at,
                         input int gap_len);
      logic [31:0] exp_q[$];
      int se, ow, n, n0, budget, t, cnt9;
      se = (s == 0) ? 1 : s;
      ow = (w - 3) / se + 1;
      n = c * ow * ow;
      for (int ch = 0; ch < c; ch++)
         for (int r = 0; r < ow; r++)
            for (int q = 0; q < ow; q++) exp_q.push_back(ref_psums(ch, w, se, r, q));
      obs_v.delete();
      obs_c.delete();
      channel_0 = 12'(c);
      width_0 = 12'(w);
      stride_0 = 3'(s);
      init_signal_0 = 1'b1;
      tick();
      init_signal_0 = 1'b0;
      n0 = cyc;
      budget = n * 9 + 30;
      t = 0;
      while (obs_v.size() < n && t < budget) begin
         if (t == gap_at) begin
            en_0 = 1'b0;
            repeat (gap_len) tick();
            en_0 = 1'b1;
         end
         tick();
         t++;
      end
      repeat (15) tick();
      check($sformatf("count_c%0d_w%0d_s%0d", c, w, s), obs_v.size(), n);
      for (int i = 0; i < obs_v.size() && i < n; i++)
         check($sformatf("psum_w%0d_s%0d_i%0d", w, s, i), obs_v[i], exp_q[i]);
      if (obs_v.size() > 0) begin
         check("first_latency", obs_c[0] - n0, 10);
         check("span", obs_c[obs_v.size()-1] - n0, 10 + 9 * (n - 1) + gap_len);
         cnt9 = 0;
         for (int i = 1; i < obs_c.size(); i++) if (obs_c[i] - obs_c[i-1] == 9) cnt9++;
         check("spacing9", cnt9, n - 1 - ((gap_len > 0) ? 1 : 0));
      end
   endtask

   initial begin
      int c, w, s;
      rst_0 = 1'b1;
      repeat (3) tick();
      rst_0 = 1'b0;
      tick();
      check("rst_vld", out_psum_vld_0, 0);
      check("rst_wd", weight_done, 0);
      check("rst_psum", {out_psum3_0, out_psum2_0, out_psum1_0, out_psum0_0}, 0);

      expect_none(1, 5, 1);

      load_weight_start = 1'b1;
      tick();
      load_weight_start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 1 || i == 9) check($sformatf("wd_during_load_%0d", i), weight_done, 0);
         if (i == 10) check("wd_after_load", weight_done, 1);
      end
      check("load_psum", {out_psum3_0, out_psum2_0, out_psum1_0, out_psum0_0}, 0);

      expect_none(1, 2, 1);
      expect_none(0, 5, 1);

      do_run(4, 5, 1, -1, 0);
      if (obs_v.size() > 0) check("first_known", obs_v[0], 32'h203A546E);
      check("wd_after_run", weight_done, 1);

      do_run(1, 7, 2, -1, 0);
      if (obs_v.size() > 1) check("w7s2_second", obs_v[1], ref_psums(0, 7, 2, 0, 1));

      do_run(1, 4, 0, -1, 0);

      for (int k = 0; k < 3; k++) begin
         c = $urandom_range(1, 3);
         w = $urandom_range(3, 9);
         s = $urandom_range(0, 3);
         do_run(c, w, s, -1, 0);
      end

      do_run(1, 5, 1, $urandom_range(12, 60), 5);

      // Abort mid-run, then confirm a fresh run starts from channel 0.
      channel_0 = 12'd2;
      width_0 = 12'd5;
      stride_0 = 3'd1;
      init_signal_0 = 1'b1;
      tick();
      init_signal_0 = 1'b0;
      repeat ($urandom_range(12, 30)) tick();
      obs_v.delete();
      addr_rst_0 = 1'b1;
      tick();
      addr_rst_0 = 1'b0;
      repeat (40) tick();
      check("addr_rst_no_strobe", obs_v.size(), 0);
      do_run(2, 5, 1, -1, 0);
      if (obs_v.size() > 0) check("addr_rst_restart", obs_v[0], 32'h203A546E);

      channel_0 = 12'd2;
      init_signal_0 = 1'b1;
      tick();
      init_signal_0 = 1'b0;
      repeat ($urandom_range(12, 30)) tick();
      obs_v.delete();
      rst_0 = 1'b1;
      tick();
      rst_0 = 1'b0;
      repeat (40) tick();
      check("rst_no_strobe", obs_v.size(), 0);
      check("rst_mid_wd", weight_done, 0);
      check("rst_mid_psum", {out_psum3_0, out_psum2_0, out_psum1_0, out_psum0_0}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/convo_core.md
Name: convo_core

Overview:
- Self-contained 3x3 convolution engine with four parallel filters.
- A weight-load phase copies a fixed internal weight table into the kernel registers.
- A run phase scans every channel plane of a generated activation image using the configured width and stride.
- Each output window emits four 8-bit partial sums (one per filter) with a valid strobe, for downstream channel accumulation.

Parameters:
- DATA_W, 8, activation, weight and psum output width
- NUM_F, 4, number of filters / psum outputs (fixed 4)
- K, 3, kernel side (fixed 3; 9 taps)
- ACC_W, 24, internal accumulator width

Ports:
- clk_0  in  1  clock; all logic on rising edge
- rst_0  in  1  reset, synchronous, active-high
- en_0  in  1  global clock enable; low freezes all state and outputs
- addr_rst_0  in  1  abort run / reset scan address counters
- channel_0  in  12  number of channel planes (C)
- stride_0  in  3  window stride (0 treated as 1)
- width_0  in  12  square image side W
- init_signal_0  in  1  one-cycle pulse: start convolution run
- load_weight_start  in  1  one-cycle pulse: start weight load
- out_psum0_0..out_psum3_0  out  8 each  psum of filters 0..3
- out_psum_vld_0  out  1  one-cycle strobe, psums valid
- weight_done  out  1  level: weights loaded

Behaviour:
- Reset: all outputs 0, FSM IDLE, kernel registers 0, counters 0. Reset mid-load or mid-run aborts immediately and clears weight_done.
- en_0=0: no state changes; inputs are not sampled.
- Internal weight table: w[f][k] = f*9 + k + 1, for f in 0..3 and tap k = kr*3 + kc in 0..8. Values are unsigned 8-bit.
- Internal activation: a(c,r,col) = (c*W*W + r*W + col) mod 256, unsigned. Generated from the address; no RAM.
- Weight load:
  - load_weight_start accepted only in IDLE.
  - Clears weight_done, then loads tap k for all 4 filters per cycle over 9 cycles.
  - weight_done rises the cycle after the 9th write and stays high until reset or the next load.
- Run start:
  - init_signal_0 accepted only in IDLE with weight_done=1, C>0 and W>=3; otherwise ignored.
  - C, W and stride are latched at acceptance.
  - OW = (W-3)/S + 1, with integer division and S = stride (0 treated as 1).
- Scan order: channel outer; then output row orow in 0..OW-1; then output column ocol in 0..OW-1.
  - Window origin is (orow*S, ocol*S).
- Window computation:
  - 9 consecutive MAC cycles, tap k=0..8.
  - All 4 filters accumulate a*w[f][k] in parallel into ACC_W accumulators.
  - On the cycle after tap 8, psum outputs load acc[7:0] (truncate, no saturation) and out_psum_vld_0 pulses high for 1 cycle.
  - The next window's tap 0 occurs in that same cycle, so vld repeats every 9 cycles.
- Latency: init accepted at edge N; taps run at edges N+1..N+9; vld high after edge N+10.
- Psum outputs hold their values between strobes.
- After the last window of the last channel: FSM returns to IDLE, weight_done stays 1, and a new init may start another run.
- Ignored inputs:
  - init_signal_0 and load_weight_start are ignored during RUN.
  - init_signal_0 is ignored during LOAD.
  - Simultaneous init and load in IDLE: load wins.
- addr_rst_0=1:
  - In RUN: abort to IDLE, clear counters and accumulators, no vld.
  - In IDLE: clear counters.
  - In LOAD: no effect.
- Total strobes per run: C*OW*OW.

Test Plan:
- Reset, then load_weight_start pulse -> weight_done=0 during load, =1 exactly 10 cycles after the pulse edge; outputs remain 0.
- C=4, W=5, S=1, init after weight_done -> 36 strobes, 9 cycles apart. First strobe: psum0..3 = 110, 84, 58, 32 (sums 366, 852, 1338, 1824 truncated).
- init_signal_0 before any weight load, or with W=2 or C=0 -> no strobes, FSM stays IDLE.
- W=7, S=2, C=1 -> OW=3, 9 strobes. Second window origin is col 2; compare against a reference model.
- en_0 held low for 5 cycles mid-run -> strobe spacing grows by exactly 5; values unchanged.
- rst_0 or addr_rst_0 asserted mid-run -> no further strobes. After rst_0, weight_done=0 and psum outputs=0. After addr_rst_0 a new init restarts from channel 0 with an identical first psum.
